// File: rtl/mul_div.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-step restoring divider that stalls the EX stage while it iterates.
module mul_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept = (state == IDLE) && valid && !flush;
    assign is_div = op[2] | op[3];

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // quo holds the remaining dividend bits in its upper end while quotient
    // bits shift in from the bottom; a zero divisor naturally yields
    // quotient all-ones and remainder equal to the dividend.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem : rem;

    always_comb begin
        busy = 1'b0;
        if (!reset && !flush) begin
            if (state == DIV)
                busy = 1'b1;
            else if (state == IDLE && valid && is_div)
                busy = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_div) state_next = DIV;
            DIV:     if (count == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op[0]) {hi, lo} <= prod_s;
                        if (op[1]) {hi, lo} <= prod_u;
                        if (op[4]) hi <= a;
                        if (op[5]) lo <= a;
                        if (is_div) begin
                            count   <= '0;
                            rem     <= '0;
                            quo     <= (op[2] && a[31]) ? -a : a;
                            divisor <= (op[2] && b[31]) ? -b : b;
                            neg_q   <= op[2] & (a[31] ^ b[31]);
                            neg_r   <= op[2] & a[31];
                        end
                    end
                end
                DIV: begin
                    count <= count + 5'd1;
                    quo   <= {quo[30:0], ~diff[32]};
                    rem   <= diff[32] ? shifted[31:0] : diff[31:0];
                end
                FINISH: begin
                    if (!flush) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div.sv
// Directed self-checking bench for mul_div: multiply, move, divide latency,
// divide-by-zero/overflow corners, flush and reset interruption.
module tb_mul_div;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] OP_MULT  = 6'b000001;
    localparam logic [5:0] OP_MULTU = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b000100;
    localparam logic [5:0] OP_DIVU  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b010000;
    localparam logic [5:0] OP_MTLO  = 6'b100000;

    mul_div dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a divide held with valid, scrambles a/b once it is in flight,
    // counts busy cycles and checks HI/LO before and after the FINISH write.
    task automatic do_div(input string tag, input logic [5:0] o,
                          input logic [31:0] ai, input logic [31:0] bi,
                          input logic [31:0] hi_old, input logic [31:0] lo_old,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        op = o; a = ai; b = bi; valid = 1'b1;
        #1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
            if (n == 1) begin
                a = ~ai;
                b = ai ^ bi ^ 32'h5A5A_0001;
            end
            #1;
        end
        check({tag, "_busy_cycles"}, n, 33);
        check({tag, "_hi_pre"}, hi, hi_old);
        check({tag, "_lo_pre"}, lo, lo_old);
        step();
        valid = 1'b0; op = '0;
        check({tag, "_hi"}, hi, hi_exp);
        check({tag, "_lo"}, lo, lo_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        step(); step();
        valid = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b0; valid = 1'b0; op = '0;

        // MULT / MULTU
        valid = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFE; b = 32'h0000_0003;
        #1;
        check("mult_busy", {31'b0, busy}, 32'd0);
        step();
        valid = 1'b0; op = '0;
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        valid = 1'b1; op = OP_MULTU;
        #1;
        check("multu_busy", {31'b0, busy}, 32'd0);
        step();
        valid = 1'b0; op = '0;
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // op=0 with valid is a no-op
        valid = 1'b1; op = '0; a = 32'h1111_1111; b = 32'h2222_2222;
        step();
        valid = 1'b0;
        check("nop_hi", hi, 32'h0000_0002);
        check("nop_lo", lo, 32'hFFFF_FFFA);

        // Divides
        do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
               32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div("divu_by0", OP_DIVU, 32'h0000_0064, 32'h0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0064, 32'hFFFF_FFFF);
        do_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0064, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_div("div_neg_by0", OP_DIV, 32'hFFFF_FFF9, 32'h0,
               32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0000_0001);
        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7,
               32'hFFFF_FFF9, 32'h0000_0001, 32'h0000_0002, 32'h0000_000E);

        // MTHI
        valid = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
        step();
        valid = 1'b0; op = '0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h0000_000E);

        // Flush at C10 of a divide
        valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        repeat (10) step();
        flush = 1'b1;
        #1;
        check("flush_c10_busy", {31'b0, busy}, 32'd0);
        step();
        flush = 1'b0; valid = 1'b0; op = '0;
        #1;
        check("flush_c11_busy", {31'b0, busy}, 32'd0);
        repeat (40) step();
        check("flush_c10_hi", hi, 32'h1234_5678);
        check("flush_c10_lo", lo, 32'h0000_000E);

        // Flush during FINISH
        begin
            int n;
            valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
            #1;
            n = 0;
            while (busy && n < 100) begin
                n++;
                step();
                #1;
            end
            check("flush_fin_cycles", n, 33);
            flush = 1'b1;
            step();
            flush = 1'b0; valid = 1'b0; op = '0;
            repeat (3) step();
            check("flush_fin_hi", hi, 32'h1234_5678);
            check("flush_fin_lo", lo, 32'h0000_000E);
        end

        // Flush while offering in IDLE suppresses acceptance
        valid = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6; flush = 1'b1;
        step();
        op = OP_DIVU;
        #1;
        check("flush_idle_busy", {31'b0, busy}, 32'd0);
        step();
        flush = 1'b0; valid = 1'b0; op = '0;
        repeat (40) step();
        check("flush_idle_hi", hi, 32'h1234_5678);
        check("flush_idle_lo", lo, 32'h0000_000E);

        // Reset at C20 of a divide, then MTLO right after
        valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        repeat (20) step();
        reset = 1'b1;
        #1;
        check("rst_c20_busy_now", {31'b0, busy}, 32'd0);
        step();
        check("rst_c20_hi", hi, 32'h0);
        check("rst_c20_lo", lo, 32'h0);
        check("rst_c20_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0; valid = 1'b1; op = OP_MTLO; a = 32'hCAFE_F00D;
        step();
        valid = 1'b0; op = '0;
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi", hi, 32'h0);
        repeat (40) step();
        check("rst_nowrite_hi", hi, 32'h0);
        check("rst_nowrite_lo", lo, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div.md
MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit operands and 64-bit HI:LO.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid  input  1  EX-stage instruction present and not squashed.
REQ-005 op  input  6  one-hot: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU, [4] MTHI, [5] MTLO.
REQ-006 a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 b  input  32  rt operand (divisor / multiplier).
REQ-008 flush  input  1  exception/flush; cancels any in-flight or offered operation.
REQ-009 busy  output  1  stall request to the EX stage; upstream holds valid/op/a/b stable while high.
REQ-010 hi  output  32  current HI register (MFHI source).
REQ-011 lo  output  32  current LO register (MFLO source).

Function
REQ-012 State machine SHALL have states IDLE, DIV, FINISH; the 5-bit iteration counter is meaningful only in DIV.
REQ-013 An operation is accepted only in IDLE with valid=1 and flush=0; op=0 with valid=1 SHALL be a no-op; multi-hot op is illegal and unverified.
REQ-014 MULT/MULTU: HI:LO SHALL take the signed/unsigned 64-bit product a*b at the accepting edge; busy stays 0; state stays IDLE.
REQ-015 MTHI/MTLO: HI (resp. LO) SHALL take a at the accepting edge; the other register is unchanged; busy stays 0.
REQ-016 DIV/DIVU accept: a, b and signedness SHALL be latched; for DIV, magnitudes |a|, |b| are used and quotient sign = a[31]^b[31], remainder sign = a[31]; state IDLE->DIV, counter=0.
REQ-017 busy SHALL be combinationally high in IDLE when valid & (op[2]|op[3]) & ~flush, high throughout DIV, and low in FINISH and otherwise.
REQ-018 DIV: one restoring radix-2 step per cycle (shift remainder, trial-subtract divisor, set quotient bit if non-negative); after step 31 (counter=31) state SHALL move to FINISH.
REQ-019 FINISH: sign-corrected quotient SHALL be written to LO and remainder to HI at the end of the cycle; state -> IDLE.
REQ-020 Timing: acceptance cycle = C0; DIV occupies C1..C32; FINISH = C33; busy high C0..C32; new HI/LO visible from C34.
REQ-021 Because busy is low in FINISH, the held instruction leaves EX at the C33 edge; the block SHALL NOT re-accept it.
REQ-022 Divide by zero SHALL take the normal latency and yield HI=a, LO=0xFFFFFFFF for DIVU; for DIV, HI=a, LO = (a[31] ? 0x00000001 : 0xFFFFFFFF).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, no trap.
REQ-024 flush=1 in any state SHALL force busy=0, return state to IDLE at the edge, suppress any acceptance and any FINISH write; HI/LO SHALL remain unchanged.
REQ-025 In DIV/FINISH, valid, op, a, b SHALL be ignored; hi/lo SHALL show the pre-division values until the FINISH write.
REQ-026 hi/lo outputs SHALL be register outputs (no bypass); a write at edge N is visible from cycle N+1.

Reset
REQ-027 reset=1 at an edge SHALL set state=IDLE, counter=0, HI=0, LO=0; busy SHALL be 0 while reset is high.
REQ-028 reset SHALL take priority over flush, valid and any in-flight division; a division interrupted by reset produces no write.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy never high; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=0x00000002 held with valid -> busy high exactly 33 cycles; from C34 lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU a=0x00000064, b=0 -> after 34 cycles hi=0x00000064, lo=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 MTHI 0x12345678 then DIVU 100/7 with flush at C10 -> busy drops in C10, state IDLE at C11, hi stays 0x12345678, lo unchanged; flush in FINISH likewise suppresses write.
REQ-033 reset asserted at C20 of a division -> hi=lo=0, busy=0 next cycle; MTLO accepted immediately after reset deasserts updates lo next cycle.
